// File: rtl/xdom_chan_ctrl.sv
// xdom_chan_ctrl: per-channel CRS control/status bank with arm/reset pulses, sticky overflow and readout handshake FSM.
// Optional readout timeout is built when XDOM_CHAN_CTRL_TIMEOUT_EN is defined.
module xdom_chan_ctrl #(
    parameter int          N_CHANNELS = 2,
    parameter int          THR_W      = 12,
    parameter logic [11:0] BASE_ADR   = 12'he00,
    parameter int          RST_LEN    = 8,
    parameter int          TIMEOUT_W  = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [11:0]                 y_adr,
    input  logic                        y_wr,
    input  logic [15:0]                 y_wr_data,
    output logic [15:0]                 y_rd_data,
    output logic                        hit,
    output logic [N_CHANNELS*THR_W-1:0] chan_thr,
    output logic [N_CHANNELS-1:0]       chan_trig_en,
    output logic [N_CHANNELS-1:0]       chan_arm,
    output logic [N_CHANNELS-1:0]       chan_rst,
    input  logic [N_CHANNELS-1:0]       chan_armed,
    input  logic [N_CHANNELS-1:0]       chan_overflow,
    input  logic                        rdout_run,
    input  logic [15:0]                 rdout_len_in,
    output logic                        rdout_busy,
    output logic [15:0]                 rdout_len
);
    localparam int RW = $clog2(RST_LEN + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t                state;
    logic [4:0]            chan_sel;
    logic [RW-1:0]         rst_cnt [N_CHANNELS];
    logic [N_CHANNELS-1:0] ovf;
    logic [THR_W-1:0]      sel_thr;
    logic                  sel_trig, wr, bc, done;
    logic [3:0]            off;
    logic [15:0]           status_rd, limit_rd;
    assign hit  = y_adr[11:4] == BASE_ADR[11:4];
    assign off  = y_adr[3:0];
    assign wr   = y_wr & hit;
    assign bc   = chan_sel == 5'h1f;
    assign done = wr && off == 4'h8 && y_wr_data[0];
`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    logic [15:0]          limit;
    logic                 timeout, lim_hit;
    assign lim_hit   = limit != 16'h0 && cnt == TIMEOUT_W'({limit, 8'h00});
    assign status_rd = {14'b0, timeout, rdout_busy};
    assign limit_rd  = limit;
`else
    assign status_rd = {15'b0, rdout_busy};
    assign limit_rd  = 16'h0;
`endif
    // Broadcast reads return channel 0; out-of-range selects match nothing.
    always_comb begin
        sel_thr  = '0;
        sel_trig = 1'b0;
        chan_rst = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (bc ? k == 0 : chan_sel == 5'(k)) begin
                sel_thr  = chan_thr[k*THR_W +: THR_W];
                sel_trig = chan_trig_en[k];
            end
            chan_rst[k] = |rst_cnt[k];
        end
    end
    always_comb begin
        y_rd_data = '0;
        if (hit)
            case (off)
                4'h0:    y_rd_data = {11'b0, chan_sel};
                4'h1:    y_rd_data = 16'(sel_thr);
                4'h2:    y_rd_data = {15'b0, sel_trig};
                4'h5:    y_rd_data = 16'(chan_armed);
                4'h6:    y_rd_data = 16'(ovf);
                4'h7:    y_rd_data = rdout_len;
                4'h8:    y_rd_data = status_rd;
                4'h9:    y_rd_data = limit_rd;
                default: y_rd_data = '0;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_sel     <= '0;
            chan_thr     <= '0;
            chan_trig_en <= '0;
            chan_arm     <= '0;
            ovf          <= '0;
            for (int k = 0; k < N_CHANNELS; k++) rst_cnt[k] <= '0;
        end else begin
            chan_arm <= (wr && off == 4'h3) ? y_wr_data[N_CHANNELS-1:0] : '0;
            // New overflow is OR'd after the clear so a same-cycle set wins.
            ovf <= (ovf & ~((wr && off == 4'h6) ? y_wr_data[N_CHANNELS-1:0] : '0)) | chan_overflow;
            if (wr && off == 4'h0) chan_sel <= y_wr_data[4:0];
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (wr && off == 4'h1 && (bc || chan_sel == 5'(k))) chan_thr[k*THR_W +: THR_W] <= y_wr_data[THR_W-1:0];
                if (wr && off == 4'h2 && (bc || chan_sel == 5'(k))) chan_trig_en[k] <= y_wr_data[0];
                rst_cnt[k] <= (wr && off == 4'h4 && y_wr_data[k]) ? RW'(RST_LEN) :
                              (rst_cnt[k] != '0) ? rst_cnt[k] - 1'b1 : '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rdout_busy <= 1'b0;
            rdout_len  <= '0;
`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
            cnt        <= '0;
            limit      <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
            if (wr && off == 4'h9) limit <= y_wr_data;
            if (wr && off == 4'h8 && y_wr_data[1]) timeout <= 1'b0;
`endif
            case (state)
                IDLE: if (rdout_run) begin
                    state      <= BUSY;
                    rdout_busy <= 1'b1;
                    rdout_len  <= rdout_len_in;
`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                BUSY: if (done) begin
                    state      <= IDLE;
                    rdout_busy <= 1'b0;
                    rdout_len  <= '0;
                end
`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
                else if (lim_hit) begin
                    state      <= IDLE;
                    rdout_busy <= 1'b0;
                    rdout_len  <= '0;
                    timeout    <= 1'b1;
                end else cnt <= &cnt ? cnt : cnt + 1'b1;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xdom_chan_ctrl.sv
// tb_xdom_chan_ctrl: directed self-checking bench for xdom_chan_ctrl with default parameters.
module tb_xdom_chan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] y_adr = 12'h0;
    logic        y_wr = 1'b0;
    logic [15:0] y_wr_data = 16'h0;
    logic [15:0] y_rd_data;
    logic        hit;
    logic [23:0] chan_thr;
    logic [1:0]  chan_trig_en, chan_arm, chan_rst;
    logic [1:0]  chan_armed = 2'b0, chan_overflow = 2'b0;
    logic        rdout_run = 1'b0;
    logic [15:0] rdout_len_in = 16'h0;
    logic        rdout_busy;
    logic [15:0] rdout_len;
    int checks = 0, failures = 0, n;

    xdom_chan_ctrl dut (
        .clk(clk), .rst(rst), .y_adr(y_adr), .y_wr(y_wr), .y_wr_data(y_wr_data),
        .y_rd_data(y_rd_data), .hit(hit), .chan_thr(chan_thr), .chan_trig_en(chan_trig_en),
        .chan_arm(chan_arm), .chan_rst(chan_rst), .chan_armed(chan_armed),
        .chan_overflow(chan_overflow), .rdout_run(rdout_run), .rdout_len_in(rdout_len_in),
        .rdout_busy(rdout_busy), .rdout_len(rdout_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [15:0] d);
        y_adr = {8'he0, off};
        y_wr_data = d;
        y_wr = 1'b1;
        @(negedge clk);
        y_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] off, input logic [15:0] exp);
        y_adr = {8'he0, off};
        #1;
        chk(tag, 64'(y_rd_data), 64'(exp));
    endtask

    task automatic run(input logic [15:0] len);
        rdout_len_in = len;
        rdout_run = 1'b1;
        @(negedge clk);
        rdout_run = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_thr", 64'(chan_thr), 64'h0);
        chk("rst_trig", 64'(chan_trig_en), 64'h0);
        chk("rst_arm", 64'(chan_arm), 64'h0);
        chk("rst_crst", 64'(chan_rst), 64'h0);
        chk("rst_busy", 64'(rdout_busy), 64'h0);
        chk("rst_len", 64'(rdout_len), 64'h0);
        for (int i = 0; i < 10; i++) rd($sformatf("rst_rd%0d", i), 4'(i), 16'h0);
        y_adr = 12'he05; #1; chk("hit_in", 64'(hit), 64'h1);
        y_adr = 12'hd05; #1; chk("hit_out", 64'(hit), 64'h0);

        wr(4'h0, 16'h1);
        wr(4'h1, 16'h0abc);
        wr(4'h0, 16'h1f);
        wr(4'h2, 16'h1);
        chk("thr_sel1", 64'(chan_thr), 64'habc000);
        chk("trig_bc", 64'(chan_trig_en), 64'h3);
        rd("rd_bc_thr", 4'h1, 16'h0);
        rd("rd_bc_trig", 4'h2, 16'h1);
        wr(4'h0, 16'h5);
        wr(4'h1, 16'h0123);
        chk("thr_drop", 64'(chan_thr), 64'habc000);
        rd("rd_sel5_thr", 4'h1, 16'h0);
        rd("rd_sel5", 4'h0, 16'h5);
        wr(4'h0, 16'h1);
        rd("rd_sel1_thr", 4'h1, 16'h0abc);
        wr(4'h1, 16'hffff);
        chk("thr_trunc", 64'(chan_thr), 64'hfff000);

        wr(4'h3, 16'h3);
        chk("arm_pulse", 64'(chan_arm), 64'h3);
        rd("rd_arm", 4'h3, 16'h0);
        @(negedge clk);
        chk("arm_end", 64'(chan_arm), 64'h0);

        wr(4'h4, 16'h2);
        chk("crst_start", 64'(chan_rst), 64'h2);
        n = 0;
        for (int i = 0; i < 40 && chan_rst[1]; i++) begin n++; @(negedge clk); end
        chk("crst_len", 64'(n), 64'd8);
        wr(4'h4, 16'h2);
        n = 0;
        repeat (4) begin if (chan_rst[1]) n++; @(negedge clk); end
        if (chan_rst[1]) n++;
        wr(4'h4, 16'h2);
        chk("crst_ch0", 64'(chan_rst[0]), 64'h0);
        for (int i = 0; i < 40 && chan_rst[1]; i++) begin n++; @(negedge clk); end
        chk("crst_ext", 64'(n), 64'd13);

        chan_overflow = 2'b01; @(negedge clk); chan_overflow = 2'b00;
        rd("ovf_set", 4'h6, 16'h1);
        chan_overflow = 2'b01;
        wr(4'h6, 16'h1);
        chan_overflow = 2'b00;
        rd("ovf_setwins", 4'h6, 16'h1);
        wr(4'h6, 16'h1);
        rd("ovf_clr", 4'h6, 16'h0);
        chan_overflow = 2'b10; @(negedge clk); chan_overflow = 2'b00;
        rd("ovf_ch1", 4'h6, 16'h2);
        chan_armed = 2'b10;
        rd("armed", 4'h5, 16'h2);

        run(16'h0100);
        chk("run_busy", 64'(rdout_busy), 64'h1);
        chk("run_len", 64'(rdout_len), 64'h100);
        rd("rd_len", 4'h7, 16'h0100);
        rd("rd_stat", 4'h8, 16'h1);
        run(16'h0200);
        chk("run2_len", 64'(rdout_len), 64'h100);
        wr(4'h8, 16'h1);
        chk("done_busy", 64'(rdout_busy), 64'h0);
        chk("done_len", 64'(rdout_len), 64'h0);
        wr(4'h8, 16'h1);
        chk("idle_done", 64'(rdout_busy), 64'h0);
        run(16'h0300);
        rdout_run = 1'b1;
        rdout_len_in = 16'h0400;
        wr(4'h8, 16'h1);
        rdout_run = 1'b0;
        chk("race_busy", 64'(rdout_busy), 64'h0);
        chk("race_len", 64'(rdout_len), 64'h0);

`ifdef XDOM_CHAN_CTRL_TIMEOUT_EN
        wr(4'h9, 16'h1);
        rd("rd_limit", 4'h9, 16'h1);
        run(16'h0055);
        repeat (250) @(negedge clk);
        chk("to_still_busy", 64'(rdout_busy), 64'h1);
        repeat (10) @(negedge clk);
        chk("to_busy", 64'(rdout_busy), 64'h0);
        chk("to_len", 64'(rdout_len), 64'h0);
        rd("to_stat", 4'h8, 16'h2);
        wr(4'h8, 16'h2);
        rd("to_clr", 4'h8, 16'h0);
`else
        wr(4'h9, 16'h1);
        rd("rd_limit_off", 4'h9, 16'h0);
        run(16'h0055);
        repeat (300) @(negedge clk);
        chk("no_to_busy", 64'(rdout_busy), 64'h1);
        rd("no_to_stat", 4'h8, 16'h1);
        wr(4'h8, 16'h1);
        chk("no_to_done", 64'(rdout_busy), 64'h0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
